// File: rtl/chip8_mem_responder.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | chip8_mem_responder: CHIP-8 4 KiB RAM with font init, CPU port, loader.    |
// | Optional: define MEM_PROTECT_EN to block CPU writes below 0x200.          |
// | Revision: 1.0                                                              |
// +---------------------------------------------------------------------------+
module chip8_mem_responder #(
   parameter int          MEM_DEPTH = 4096,
   parameter logic [11:0] FONT_BASE = 12'h050,
   parameter int          FONT_LEN  = 80
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [11:0] mem_addr_in,
   input  logic [7:0]  mem_wdata,
   output logic [7:0]  mem_rdata,
   input  logic        load_we,
   input  logic [11:0] load_addr,
   input  logic [7:0]  load_data,
   output logic        ready,
   output logic        protect_err
);

   localparam logic [0:0] ST_INIT = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   // Glyphs 0..F, first byte in the most significant position.
   localparam logic [639:0] FONT_ROM = {
      64'hF0909090F0206020, 64'h2070F010F080F0F0, 64'h10F010F09090F010, 64'h10F080F010F0F080,
      64'hF090F0F010204040, 64'hF090F090F0F090F0, 64'h10F0F090F09090E0, 64'h90E090E0F0808080,
      64'hF0E0909090E0F080, 64'hF080F0F080F08080
   };

   logic [0:0]  state;
   logic [6:0]  cnt;
   logic [7:0]  ram [0:MEM_DEPTH-1];
   logic        cpu_ok;
   logic        wr_en;
   logic [11:0] wr_addr;
   logic [7:0]  wr_data;
   logic [7:0]  font_byte;

   assign font_byte = FONT_ROM[(FONT_LEN - 1 - int'(cnt)) * 8 +: 8];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_INIT;
         cnt   <= 7'd0;
         ready <= 1'b0;
      end else if (state == ST_INIT) begin
         cnt <= cnt + 7'd1;
         if (cnt == 7'(FONT_LEN - 1)) begin
            state <= ST_RUN;
            ready <= 1'b1;
         end
      end
   end

`ifdef MEM_PROTECT_EN
   assign cpu_ok = mem_write && (mem_addr_in >= 12'h200);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         protect_err <= 1'b0;
      end else if (state == ST_RUN && mem_write && mem_addr_in < 12'h200) begin
         protect_err <= 1'b1;
      end
   end
`else
   assign cpu_ok      = mem_write;
   assign protect_err = 1'b0;
`endif

   // Loader has priority over the CPU; nothing is written while reset is held.
   always_comb begin
      wr_en   = 1'b0;
      wr_addr = mem_addr_in;
      wr_data = mem_wdata;
      if (reset_n) begin
         if (state == ST_INIT) begin
            wr_en   = 1'b1;
            wr_addr = FONT_BASE + {5'd0, cnt};
            wr_data = font_byte;
         end else if (load_we) begin
            wr_en   = 1'b1;
            wr_addr = load_addr;
            wr_data = load_data;
         end else if (cpu_ok) begin
            wr_en   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         ram[wr_addr] <= wr_data;
      end
   end

   // Read sees the pre-write byte because the RAM update is non-blocking.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem_rdata <= 8'h00;
      end else if (state == ST_RUN && mem_read) begin
         mem_rdata <= ram[mem_addr_in];
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_chip8_mem_responder.sv
`default_nettype none
// Testbench for chip8_mem_responder: directed steps plus randomized traffic
// checked against an array model of the RAM.
module tb_chip8_mem_responder;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        mem_read, mem_write, load_we;
   logic [11:0] mem_addr_in, load_addr;
   logic [7:0]  mem_wdata, load_data;
   logic [7:0]  mem_rdata;
   logic        ready, protect_err;

   chip8_mem_responder dut (
      .clk(clk), .reset_n(reset_n),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr_in(mem_addr_in),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
      .ready(ready), .protect_err(protect_err)
   );

   always #5 clk = ~clk;

   logic [7:0] font [80] = '{
      8'hF0,8'h90,8'h90,8'h90,8'hF0, 8'h20,8'h60,8'h20,8'h20,8'h70,
      8'hF0,8'h10,8'hF0,8'h80,8'hF0, 8'hF0,8'h10,8'hF0,8'h10,8'hF0,
      8'h90,8'h90,8'hF0,8'h10,8'h10, 8'hF0,8'h80,8'hF0,8'h10,8'hF0,
      8'hF0,8'h80,8'hF0,8'h90,8'hF0, 8'hF0,8'h10,8'h20,8'h40,8'h40,
      8'hF0,8'h90,8'hF0,8'h90,8'hF0, 8'hF0,8'h90,8'hF0,8'h10,8'hF0,
      8'hF0,8'h90,8'hF0,8'h90,8'h90, 8'hE0,8'h90,8'hE0,8'h90,8'hE0,
      8'hF0,8'h80,8'h80,8'h80,8'hF0, 8'hE0,8'h90,8'h90,8'h90,8'hE0,
      8'hF0,8'h80,8'hF0,8'h80,8'hF0, 8'hF0,8'h80,8'hF0,8'h80,8'h80};

`ifdef MEM_PROTECT_EN
   localparam bit PROT = 1'b1;
`else
   localparam bit PROT = 1'b0;
`endif

   logic [7:0] model [4096];
   logic [7:0] exp_rdata;
   logic       exp_perr;
   int checks = 0;
   int passes = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) passes++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      mem_read = 0; mem_write = 0; load_we = 0;
   endtask

   // Counts edges after reset release until ready; optionally probes a read at init cycle 10.
   task automatic wait_ready(input bit probe, output int n);
      n = 0;
      while (!ready && n < 200) begin
         if (probe && n == 9) begin
            mem_read = 1; mem_addr_in = 12'h050;
         end
         step();
         n++;
         if (probe && n == 10) begin
            idle();
            chk("init_read_ignored", {24'd0, mem_rdata}, 32'h00);
         end
      end
      idle();
      for (int i = 0; i < 80; i++) model[12'h050 + 12'(i)] = font[i];
   endtask

   task automatic rd(input logic [11:0] a);
      mem_read = 1; mem_addr_in = a;
      step();
      mem_read = 0;
   endtask

   task automatic ld(input logic [11:0] a, input logic [7:0] d);
      load_we = 1; load_addr = a; load_data = d;
      step();
      load_we = 0;
      model[a] = d;
   endtask

   function automatic logic [11:0] pick_addr();
      if ($urandom_range(0, 1) == 0) return 12'h050 + 12'($urandom_range(0, 79));
      return 12'h200 + 12'($urandom_range(0, 63));
   endfunction

   initial begin
      int n;
      logic [11:0] ca, la;
      logic [7:0]  wd, lv;
      bit r, w, l;

      reset_n = 0; idle();
      mem_addr_in = 0; mem_wdata = 0; load_addr = 0; load_data = 0;
      exp_perr = 0;
      repeat (3) step();
      chk("reset_rdata", {24'd0, mem_rdata}, 32'h00);
      chk("reset_ready", {31'd0, ready}, 32'd0);
      chk("reset_perr", {31'd0, protect_err}, 32'd0);

      reset_n = 1;
      wait_ready(1'b1, n);
      chk("init_cycles", n, 32'd80);
      rd(12'h050); chk("font_050", {24'd0, mem_rdata}, 32'hF0);
      rd(12'h051); chk("font_051", {24'd0, mem_rdata}, 32'h90);
      rd(12'h09F); chk("font_09F", {24'd0, mem_rdata}, 32'h80);
      for (int i = 0; i < 80; i += 7) begin
         rd(12'h050 + 12'(i));
         chk("font_scan", {24'd0, mem_rdata}, {24'd0, font[i]});
      end

      ld(12'h200, 8'h12); ld(12'h201, 8'h34);
      rd(12'h200); chk("load_rd_200", {24'd0, mem_rdata}, 32'h12);
      step();      chk("rd_hold", {24'd0, mem_rdata}, 32'h12);
      rd(12'h201); chk("load_rd_201", {24'd0, mem_rdata}, 32'h34);

      ld(12'h300, 8'hAA);
      mem_read = 1; mem_write = 1; mem_addr_in = 12'h300; mem_wdata = 8'h55;
      step(); idle();
      chk("rbw_old", {24'd0, mem_rdata}, 32'hAA);
      rd(12'h300); chk("rbw_new", {24'd0, mem_rdata}, 32'h55);

      load_we = 1; load_addr = 12'h400; load_data = 8'h11;
      mem_read = 1; mem_write = 1; mem_addr_in = 12'h400; mem_wdata = 8'h22;
      model[12'h400] = 8'h00;
      ld(12'h400, 8'h66);
      load_we = 1; load_addr = 12'h400; load_data = 8'h11;
      mem_read = 1; mem_write = 1; mem_addr_in = 12'h400; mem_wdata = 8'h22;
      step(); idle();
      chk("load_wins_rd_old", {24'd0, mem_rdata}, 32'h66);
      rd(12'h400); chk("load_wins", {24'd0, mem_rdata}, 32'h11);

      ld(12'h1FF, 8'h5A);
      mem_write = 1; mem_addr_in = 12'h1FF; mem_wdata = 8'h77;
      step(); idle();
      exp_perr = PROT;
      rd(12'h1FF);
      chk("low_write", {24'd0, mem_rdata}, PROT ? 32'h5A : 32'h77);
      chk("perr_set", {31'd0, protect_err}, {31'd0, exp_perr});

      for (int i = 0; i < 64; i++) ld(12'h200 + 12'(i), 8'($urandom));
      exp_rdata = mem_rdata;
      for (int i = 0; i < 300; i++) begin
         r = 1'($urandom); w = 1'($urandom); l = ($urandom_range(0, 3) == 0);
         ca = pick_addr(); la = pick_addr(); wd = 8'($urandom); lv = 8'($urandom);
         mem_read = r; mem_write = w; mem_addr_in = ca; mem_wdata = wd;
         load_we = l; load_addr = la; load_data = lv;
         if (r) exp_rdata = model[ca];
         if (w && PROT && ca < 12'h200) exp_perr = 1;
         if (l) model[la] = lv;
         else if (w && !(PROT && ca < 12'h200)) model[ca] = wd;
         step(); idle();
         chk("rand_rdata", {24'd0, mem_rdata}, {24'd0, exp_rdata});
         chk("rand_perr", {31'd0, protect_err}, {31'd0, exp_perr});
      end

      mem_read = 1; mem_addr_in = 12'h200;
      step(); idle();
      #2 reset_n = 0;
      #1;
      chk("async_rst_rdata", {24'd0, mem_rdata}, 32'h00);
      chk("async_rst_ready", {31'd0, ready}, 32'd0);
      chk("async_rst_perr", {31'd0, protect_err}, 32'd0);
      repeat (3) step();
      reset_n = 1;
      repeat (20) step();
      chk("midinit_ready", {31'd0, ready}, 32'd0);
      reset_n = 0;
      repeat (3) step();
      chk("pulse_ready", {31'd0, ready}, 32'd0);
      reset_n = 1;
      wait_ready(1'b0, n);
      chk("reinit_cycles", n, 32'd80);
      chk("reinit_rdata", {24'd0, mem_rdata}, 32'h00);
      chk("reinit_perr", {31'd0, protect_err}, 32'd0);
      for (int i = 0; i < 80; i += 3) begin
         rd(12'h050 + 12'(i));
         chk("refont", {24'd0, mem_rdata}, {24'd0, model[12'h050 + 12'(i)]});
      end
      rd(12'h201); chk("ram_kept", {24'd0, mem_rdata}, {24'd0, model[12'h201]});

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
`default_nettype wire
